vip_frame_scheduler: RTL and testbench

//  Frame sequencer in front of the VIP colour-space pipeline (RGB888->YCbCr444 and successors).

---
 rtl/vip_pkg.sv | 27 ++
 rtl/vip_frame_scheduler_if.sv | 16 +
 rtl/vip_sched_counter.sv | 28 ++
 rtl/vip_frame_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_vip_frame_scheduler.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vip_pkg.sv
// Shared types for the VIP frame scheduler: FSM state encoding, the RGB888
// pixel layout and the width and load helper for the blanking duration counter.
package vip_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEAD   = 3'd1,
        ACTIVE = 3'd2,
        HBLANK = 3'd3,
        TAIL   = 3'd4,
        GAP    = 3'd5
    } sched_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    localparam int BLANK_W = 16;

    // A duration of N cycles is loaded as N-1 and ends when the counter reads 0.
    function automatic logic [BLANK_W-1:0] dur_load(input int cycles);
        return BLANK_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/vip_frame_scheduler_if.sv
// Upstream pixel stream between a RGB888 source and the frame scheduler.
//
// Handshake: a pixel moves on every rising clk edge where s_valid and s_ready
// are both 1. The source holds s_data steady while s_valid=1 and s_ready=0.
// s_ready never depends combinationally on s_valid.
interface vip_frame_scheduler_if;
    import vip_pkg::*;

    logic    s_valid;
    logic    s_ready;
    rgb888_t s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/vip_sched_counter.sv
// Load/decrement duration counter used for the LEAD, HBLANK, TAIL and GAP
// phases. It stops at zero rather than wrapping, and tc flags the final cycle.
module vip_sched_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] count;

    // Load on phase entry, otherwise count down and hold at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/vip_frame_scheduler.sv
// Frame sequencer feeding the VIP colour-space pipeline. Pulls RGB pixels from
// an upstream valid/ready source and emits per_img_vsync/href/RGB with fixed
// frame shape and blanking.
// Optional build macro VIP_FRAME_SCHED_STATS_EN adds the frame_cnt and
// underrun_cnt status outputs.
module vip_frame_scheduler
    import vip_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int VS_LEAD    = 5,
    parameter int H_BLANK    = 10,
    parameter int V_TAIL     = 1,
    parameter int FRAME_GAP  = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   cont_mode,
    output logic                   busy,
    output logic                   frame_done,
    vip_frame_scheduler_if.slave   s_if,
    output logic                   per_img_vsync,
    output logic                   per_img_href,
    output logic [7:0]             per_img_red,
    output logic [7:0]             per_img_green,
    output logic [7:0]             per_img_blue
`ifdef VIP_FRAME_SCHED_STATS_EN
    ,
    output logic [15:0]            frame_cnt,
    output logic [15:0]            underrun_cnt
`endif
);

    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    sched_state_t         state;
    sched_state_t         state_nxt;
    logic [CW-1:0]        col;
    logic [RW-1:0]        row;
    logic                 accept;
    logic                 line_end;
    logic                 last_line;
    logic                 frame_end;
    logic                 blank_load;
    logic [BLANK_W-1:0]   blank_val;
    logic                 blank_tc;
    rgb888_t              pix_q;
    logic                 href_q;
    logic                 done_q;

    // The accept window is decoded from the state register only.
    assign s_if.s_ready = (state == ACTIVE);
    assign accept       = s_if.s_valid && (state == ACTIVE);
    assign line_end     = accept && (col == CW'(IMG_WIDTH - 1));
    assign last_line    = (row == RW'(IMG_HEIGHT - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; frame_end marks the last TAIL cycle.
    always_comb begin
        state_nxt = state;
        frame_end = 1'b0;
        case (state)
            IDLE: begin
                // A start arriving with the frame_done pulse is ignored.
                if (start && !done_q) begin
                    state_nxt = LEAD;
                end
            end
            LEAD: begin
                if (blank_tc) begin
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (line_end) begin
                    state_nxt = last_line ? TAIL : HBLANK;
                end
            end
            HBLANK: begin
                if (blank_tc) begin
                    state_nxt = ACTIVE;
                end
            end
            TAIL: begin
                if (blank_tc) begin
                    frame_end = 1'b1;
                    state_nxt = cont_mode ? GAP : IDLE;
                end
            end
            GAP: begin
                if (blank_tc) begin
                    state_nxt = LEAD;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Load the duration counter on entry into each timed phase.
    always_comb begin
        blank_load = 1'b0;
        blank_val  = '0;
        if (state_nxt != state) begin
            case (state_nxt)
                LEAD: begin
                    blank_load = 1'b1;
                    blank_val  = dur_load(VS_LEAD);
                end
                HBLANK: begin
                    blank_load = 1'b1;
                    blank_val  = dur_load(H_BLANK);
                end
                TAIL: begin
                    blank_load = 1'b1;
                    blank_val  = dur_load(V_TAIL);
                end
                GAP: begin
                    blank_load = 1'b1;
                    blank_val  = dur_load(FRAME_GAP);
                end
                default: begin
                    blank_load = 1'b0;
                end
            endcase
        end
    end

    vip_sched_counter #(
        .W (BLANK_W)
    ) u_blank_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (blank_load),
        .load_val (blank_val),
        .tc       (blank_tc)
    );

    // Column/row position; cleared during LEAD so each frame starts at 0,0.
    always_ff @(posedge clk) begin
        if (rst || (state == LEAD)) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == CW'(IMG_WIDTH - 1)) begin
                col <= '0;
                if (!last_line) begin
                    row <= row + RW'(1);
                end
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Registered pixel path: one cycle from accept to href; RGB holds when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            href_q <= 1'b0;
            pix_q  <= '0;
            done_q <= 1'b0;
        end else begin
            href_q <= accept;
            done_q <= frame_end;
            if (accept) begin
                pix_q <= s_if.s_data;
            end
        end
    end

    assign busy          = (state != IDLE);
    assign frame_done    = done_q;
    assign per_img_vsync = (state == LEAD) || (state == ACTIVE) ||
                           (state == HBLANK) || (state == TAIL);
    assign per_img_href  = href_q;
    assign per_img_red   = pix_q.r;
    assign per_img_green = pix_q.g;
    assign per_img_blue  = pix_q.b;

`ifdef VIP_FRAME_SCHED_STATS_EN
    // Frame counter wraps; underrun counter saturates and restarts per frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt    <= '0;
            underrun_cnt <= '0;
        end else begin
            if (frame_end) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if ((state_nxt == LEAD) && (state != LEAD)) begin
                underrun_cnt <= '0;
            end else if ((state == ACTIVE) && !accept && (underrun_cnt != 16'hFFFF)) begin
                underrun_cnt <= underrun_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vip_frame_scheduler.sv
// Bench for vip_frame_scheduler with a small 4x2 frame. Each scenario is laid
// out as a cycle timeline built from the frame-shape rules, then replayed into
// the DUT with per-cycle checks of every output.
module tb_vip_frame_scheduler;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int VL   = 5;
    localparam int HB   = 3;
    localparam int VT   = 1;
    localparam int FG   = 2;
    localparam int MAXC = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        cont_mode;
    logic        busy;
    logic        frame_done;
    logic        vs;
    logic        href;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
`ifdef VIP_FRAME_SCHED_STATS_EN
    logic [15:0] frame_cnt;
    logic [15:0] underrun_cnt;
`endif

    vip_frame_scheduler_if bus ();

    vip_frame_scheduler #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .VS_LEAD    (VL),
        .H_BLANK    (HB),
        .V_TAIL     (VT),
        .FRAME_GAP  (FG)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cont_mode     (cont_mode),
        .busy          (busy),
        .frame_done    (frame_done),
        .s_if          (bus),
        .per_img_vsync (vs),
        .per_img_href  (href),
        .per_img_red   (red),
        .per_img_green (green),
        .per_img_blue  (blue)
`ifdef VIP_FRAME_SCHED_STATS_EN
        ,
        .frame_cnt     (frame_cnt),
        .underrun_cnt  (underrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Stimulus timeline
    logic        st_rst   [MAXC];
    logic        st_start [MAXC];
    logic        st_cont  [MAXC];
    logic        st_valid [MAXC];
    logic [23:0] st_data  [MAXC];
    // Expected outputs per cycle
    logic        e_vs     [MAXC];
    logic        e_href   [MAXC];
    logic        e_ready  [MAXC];
    logic        e_fd     [MAXC];
    logic        e_busy   [MAXC];
    logic [23:0] e_rgb    [MAXC];

    int          n_cyc;
    int          exp_href_total;
    int          exp_fd_total;
    int          exp_frames;
    int          exp_underrun;
    logic [23:0] rgb_prev;

    task automatic chk(input string tag, input int cyc, input logic [23:0] obs, input logic [23:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < MAXC; i++) begin
            st_rst[i]   = 1'b0;
            st_start[i] = 1'b0;
            st_cont[i]  = 1'b0;
            st_valid[i] = 1'b0;
            st_data[i]  = '0;
            e_vs[i]     = 1'b0;
            e_href[i]   = 1'b0;
            e_ready[i]  = 1'b0;
            e_fd[i]     = 1'b0;
            e_busy[i]   = 1'b0;
            e_rgb[i]    = '0;
        end
    endtask

    // Reset held for n cycles: every output 0, status cleared.
    task automatic build_reset(input int n);
        clear_all();
        for (int i = 0; i < n; i++) st_rst[i] = 1'b1;
        n_cyc          = n;
        rgb_prev       = '0;
        exp_frames     = 0;
        exp_underrun   = 0;
        exp_href_total = 0;
        exp_fd_total   = 0;
    endtask

    // Lay out nf frames beginning with a start pulse in cycle s.
    // rst_acc >= 0 asserts rst in the cycle where that accept would occur.
    // stall_at >= 0 forces s_valid low for two cycles there.
    task automatic build(input int s, input int nf, input bit rnd_valid, input bit rnd_ctl,
                         input int rst_acc, input int stall_at, input bit ramp_data);
        int t;
        int acc;
        int rcyc;
        int fd_last;
        logic [23:0] cur;
        clear_all();
        for (int i = 0; i < MAXC; i++) begin
            st_data[i]  = ramp_data ? (24'h010203 + 24'(i)) : 24'($urandom);
            st_valid[i] = rnd_valid ? (($urandom_range(0, 3) != 0) || (i % 4 == 0)) : 1'b1;
            if (rnd_ctl) st_cont[i] = 1'($urandom_range(0, 1));
        end
        if (stall_at >= 0) begin
            st_valid[stall_at]     = 1'b0;
            st_valid[stall_at + 1] = 1'b0;
        end
        st_start[s] = 1'b1;
        t    = s + 1;
        acc  = 0;
        rcyc = -1;
        for (int f = 0; f < nf; f++) begin
            exp_underrun = 0;
            for (int k = 0; k < VL; k++) begin
                e_vs[t] = 1'b1; e_busy[t] = 1'b1; t++;
            end
            for (int r = 0; r < H; r++) begin
                for (int c = 0; c < W; c++) begin
                    while (!st_valid[t]) begin
                        e_vs[t] = 1'b1; e_busy[t] = 1'b1; e_ready[t] = 1'b1;
                        exp_underrun++; t++;
                    end
                    e_vs[t] = 1'b1; e_busy[t] = 1'b1; e_ready[t] = 1'b1;
                    e_href[t + 1] = 1'b1;
                    e_rgb[t + 1]  = st_data[t];
                    if (acc == rst_acc && rcyc < 0) rcyc = t;
                    acc++; t++;
                end
                if (r < H - 1) begin
                    for (int k = 0; k < HB; k++) begin
                        e_vs[t] = 1'b1; e_busy[t] = 1'b1; t++;
                    end
                end
            end
            for (int k = 0; k < VT; k++) begin
                e_vs[t] = 1'b1; e_busy[t] = 1'b1; t++;
            end
            e_fd[t]        = 1'b1;
            st_cont[t - 1] = (f < nf - 1);
            if (f < nf - 1) begin
                for (int k = 0; k < FG; k++) begin
                    e_busy[t] = 1'b1; t++;
                end
            end
        end
        fd_last = t;
        if (rnd_ctl) begin
            for (int i = s + 1; i <= fd_last; i++) st_start[i] = ($urandom_range(0, 3) == 0);
        end
        cur = rgb_prev;
        for (int i = 0; i < MAXC; i++) begin
            if (e_href[i]) cur = e_rgb[i];
            e_rgb[i] = cur;
        end
        if (rcyc >= 0) begin
            st_rst[rcyc] = 1'b1;
            for (int i = rcyc + 1; i < MAXC; i++) begin
                st_start[i] = 1'b0;
                e_vs[i] = 1'b0; e_href[i] = 1'b0; e_ready[i] = 1'b0;
                e_fd[i] = 1'b0; e_busy[i] = 1'b0; e_rgb[i] = '0;
            end
            n_cyc          = rcyc + 4;
            exp_href_total = rst_acc;
            exp_fd_total   = 0;
            exp_frames     = 0;
            exp_underrun   = 0;
        end else begin
            n_cyc          = fd_last + 4;
            exp_href_total = W * H * nf;
            exp_fd_total   = nf;
            exp_frames     = exp_frames + nf;
        end
        rgb_prev = e_rgb[n_cyc - 1];
    endtask

    // Replay the timeline: drive just after posedge, check at negedge.
    task automatic run_scn(input string name);
        int hc;
        int fc;
        hc = 0;
        fc = 0;
        for (int i = 0; i < n_cyc; i++) begin
            rst         = st_rst[i];
            start       = st_start[i];
            cont_mode   = st_cont[i];
            bus.s_valid = st_valid[i];
            bus.s_data  = st_data[i];
            @(negedge clk);
            chk({name, ".vsync"},      i, 24'(vs),          24'(e_vs[i]));
            chk({name, ".href"},       i, 24'(href),        24'(e_href[i]));
            chk({name, ".rgb"},        i, {red, green, blue}, e_rgb[i]);
            chk({name, ".s_ready"},    i, 24'(bus.s_ready), 24'(e_ready[i]));
            chk({name, ".frame_done"}, i, 24'(frame_done),  24'(e_fd[i]));
            chk({name, ".busy"},       i, 24'(busy),        24'(e_busy[i]));
            if (href === 1'b1) hc++;
            if (frame_done === 1'b1) fc++;
            @(posedge clk);
            #1;
        end
        chk({name, ".href_total"}, n_cyc, 24'(hc), 24'(exp_href_total));
        chk({name, ".fd_total"},   n_cyc, 24'(fc), 24'(exp_fd_total));
`ifdef VIP_FRAME_SCHED_STATS_EN
        chk({name, ".frame_cnt"},    n_cyc, 24'(frame_cnt),    24'(exp_frames));
        chk({name, ".underrun_cnt"}, n_cyc, 24'(underrun_cnt), 24'(exp_underrun));
`endif
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        cont_mode   = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        @(posedge clk);
        #1;
        // Reset held, all outputs low
        build_reset(3);
        run_scn("reset");
        // Single frame, continuous valid, ramp data
        build(2, 1, 1'b0, 1'b0, -1, -1, 1'b1);
        run_scn("basic");
        // Two-cycle underrun at row 0 col 2
        build(2, 1, 1'b0, 1'b0, -1, 2 + 1 + VL + 2, 1'b0);
        run_scn("underrun");
        // Continuous mode, three frames, random valid and stray starts
        build(1, 3, 1'b1, 1'b1, -1, -1, 1'b0);
        run_scn("cont");
        // Single frame with random starts while busy
        build(1, 1, 1'b1, 1'b1, -1, -1, 1'b0);
        run_scn("start_busy");
        // Reset at row 1 col 2
        build(1, 1, 1'b1, 1'b1, W + 2, -1, 1'b0);
        run_scn("mid_rst");
        // Clean frame after the abandoned one
        build(1, 1, 1'b1, 1'b0, -1, -1, 1'b0);
        run_scn("after_rst");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
